// File: rtl/risc_toy_pkg.sv
// Shared RISC_TOY definitions: opcodes, address width, fetch-entry record.
// The ctrl field exists only when IFETCH_PREDECODE_EN is defined.
package risc_toy_pkg;

  localparam int IAW = 30;

  localparam logic [4:0] OP_ADD = 5'b00100;
  localparam logic [4:0] OP_BR  = 5'b01111;
  localparam logic [4:0] OP_BRL = 5'b10000;
  localparam logic [4:0] OP_J   = 5'b10001;
  localparam logic [4:0] OP_JL  = 5'b10010;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]    instr;
    logic [IAW-1:0] pc;
`ifdef IFETCH_PREDECODE_EN
    logic           ctrl;
`endif
  } fetch_entry_t;

  function automatic logic is_ctrl_op(input logic [4:0] op);
    return (op == OP_BR) || (op == OP_BRL) || (op == OP_J) || (op == OP_JL);
  endfunction

endpackage

// File: rtl/risc_toy_ifetch_if.sv
// Fetch-unit bus: instruction memory, decode handshake and execute redirect.
// IF_CTRL is present only when IFETCH_PREDECODE_EN is defined.
interface risc_toy_ifetch_if;
  import risc_toy_pkg::*;

  logic           IREQ;
  logic [IAW-1:0] IADDR;
  logic [31:0]    INSTR;
  logic           IF_VALID;
  logic           IF_READY;
  logic [31:0]    IF_INSTR;
  logic [IAW-1:0] IF_PC;
  logic           RDIR_EN;
  logic [IAW-1:0] RDIR_ADDR;
`ifdef IFETCH_PREDECODE_EN
  logic           IF_CTRL;

  modport master (
    output IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC, IF_CTRL,
    input  INSTR, IF_READY, RDIR_EN, RDIR_ADDR
  );
  modport slave (
    input  IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC, IF_CTRL,
    output INSTR, IF_READY, RDIR_EN, RDIR_ADDR
  );
`else
  modport master (
    output IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC,
    input  INSTR, IF_READY, RDIR_EN, RDIR_ADDR
  );
  modport slave (
    input  IREQ, IADDR, IF_VALID, IF_INSTR, IF_PC,
    output INSTR, IF_READY, RDIR_EN, RDIR_ADDR
  );
`endif

endinterface

// File: rtl/ifetch_fifo.sv
// DEPTH-entry prefetch FIFO with synchronous flush; DEPTH must be a power of two
// so the pointers wrap naturally. Flush wins over a same-cycle push or pop.
module ifetch_fifo
  import risc_toy_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push & ~flush;
    do_pop   = pop & ~flush & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/risc_toy_ifetch.sv
// RISC_TOY fetch front-end: credit-checked sequential prefetch into ifetch_fifo,
// flush/kill on redirect. IFETCH_PREDECODE_EN adds the IF_CTRL predecode bit.
module risc_toy_ifetch
  import risc_toy_pkg::*;
#(
  parameter int             DEPTH      = 4,
  parameter logic [IAW-1:0] RESET_ADDR = '0
) (
  input logic               CLK,
  input logic               RSTN,
  risc_toy_ifetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e   state_q, state_d;
  logic [IAW-1:0] pc_q, pc_d;
  logic [IAW-1:0] req_pc_q, req_pc_d;
  logic           inflight_q, inflight_d;
  logic           kill_q, kill_d;
  logic           issue, pop, push, fifo_valid;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occ_after_pop;
  fetch_entry_t   push_entry, head_entry;

  always_comb begin
    state_d       = ST_RUN;
    pop           = fifo_valid & bus.IF_READY;
    occ_after_pop = (CW+1)'(fifo_count) + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue         = (state_q == ST_RUN) & ~bus.RDIR_EN & (occ_after_pop < (CW+1)'(DEPTH));
    // Redirect drops the response arriving this cycle as well as the pop.
    push          = inflight_q & ~kill_q & ~bus.RDIR_EN;
    inflight_d    = issue;
    kill_d        = bus.RDIR_EN & inflight_q;
    req_pc_d      = issue ? pc_q : req_pc_q;
    pc_d          = pc_q;
    if (bus.RDIR_EN)  pc_d = bus.RDIR_ADDR;
    else if (issue)   pc_d = pc_q + IAW'(1);
    push_entry.instr = bus.INSTR;
    push_entry.pc    = req_pc_q;
`ifdef IFETCH_PREDECODE_EN
    push_entry.ctrl  = is_ctrl_op(bus.INSTR[31:27]);
`endif
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_ADDR;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (CLK),
    .rst_n     (RSTN),
    .flush     (bus.RDIR_EN),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign bus.IREQ     = issue;
  assign bus.IADDR    = pc_q;
  assign bus.IF_VALID = fifo_valid;
  assign bus.IF_INSTR = fifo_valid ? head_entry.instr : '0;
  assign bus.IF_PC    = fifo_valid ? head_entry.pc : '0;
`ifdef IFETCH_PREDECODE_EN
  assign bus.IF_CTRL  = fifo_valid & head_entry.ctrl;
`endif

endmodule
